// File: rtl/bcd_seg_pkg.sv
// Shared constants, FSM state type and parameter checks for bcd_seg_converter.
package bcd_seg_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned SEG_W       = 7;

  // Active-low segments, bit order g..a
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True when 10**digits exceeds the largest width-bit value.
  function automatic bit digits_fit(input int unsigned digits, input int unsigned width);
    longint unsigned p;
    longint unsigned max_v;
    p     = 64'd1;
    max_v = (64'd1 << width) - 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      // Stop growing once large enough so the product cannot overflow
      if (p <= max_v) p = p * 64'd10;
    end
    return p > max_v;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// One BCD digit to active-low seven-segment pattern (g..a), with forced blank.
// Ports:
//   digit  - 4-bit BCD digit
//   blank  - 1 forces all segments off
//   seg_c  - combinational active-low segments, bit 6 = g, bit 0 = a
module seven_seg_decoder
  import bcd_seg_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  input  logic                   blank,
  output logic [SEG_W-1:0]       seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_converter.sv
// Sequential double-dabble binary-to-BCD converter driving one active-low
// seven-segment display per digit. One input bit is consumed per clock.
// Optional feature macro: BCD_SEG_LEADING_ZERO_BLANK_EN blanks leading zero
// digits (digit 0 is always shown).
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   start  - conversion request, accepted only in IDLE
//   bin    - WIDTH-bit binary value, sampled on the accepting edge
//   busy   - high while converting or presenting the result
//   done   - one-cycle pulse when bcd holds a new result
//   bcd    - result register, digit k at [4k+3:4k]
//   seg    - active-low segments, digit k at [7k+6:7k]
module bcd_seg_converter
  import bcd_seg_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [SEG_W*DIGITS-1:0]       seg
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Parameter legality checks
  if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
    $error("bcd_seg_converter: WIDTH must be in 1..31");
  end
  if (!digits_fit(DIGITS, WIDTH)) begin : g_bad_digits
    $error("bcd_seg_converter: DIGITS too small for WIDTH");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic [BCD_W-1:0]   scr_adj_c;
  logic [BCD_W-1:0]   scr_shift_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_d;
  logic               busy_d, done_d;
  logic [DIGITS-1:0]  blank_c;

  // Add-3 correction on every scratch digit >= 5 before shifting
  always_comb begin
    scr_adj_c = scr_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (scr_q[k*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5) begin
        scr_adj_c[k*BCD_DIGIT_W +: BCD_DIGIT_W] =
          scr_q[k*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end
    end
  end

  // Top bit of the binary shift register enters BCD digit 0
  assign scr_shift_c = {scr_adj_c[BCD_W-2:0], sh_q[WIDTH-1]};

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q_view();
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = bin;
          scr_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = scr_shift_c;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scr_shift_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  function automatic logic [BCD_W-1:0] bcd_q_view();
    return bcd;
  endfunction

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd     <= bcd_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

`ifdef BCD_SEG_LEADING_ZERO_BLANK_EN
  // Blank every digit above the most significant nonzero digit
  always_comb begin
    logic lead;
    blank_c = '0;
    lead    = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (bcd[k*BCD_DIGIT_W +: BCD_DIGIT_W] != 4'd0) lead = 1'b0;
      blank_c[k] = lead;
    end
  end
`else
  assign blank_c = '0;
`endif

  // One decoder per digit, driven from the result register only
  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    seven_seg_decoder u_dec (
      .digit (bcd[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .blank (blank_c[k]),
      .seg_c (seg[k*SEG_W +: SEG_W])
    );
  end

endmodule

// File: tb/tb_bcd_seg_converter.sv
module tb_bcd_seg_converter;

  logic        clk;
  logic        reset;

  logic        start;
  logic [7:0]  bin;
  logic        busy, done;
  logic [11:0] bcd;
  logic [20:0] seg;

  logic        start16;
  logic [15:0] bin16;
  logic        busy16, done16;
  logic [19:0] bcd16;
  logic [34:0] seg16;

  logic        start1;
  logic [0:0]  bin1;
  logic        busy1, done1;
  logic [3:0]  bcd1;
  logic [6:0]  seg1;

  int tests;
  int fails;

  bcd_seg_converter #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .seg(seg)
  );

  bcd_seg_converter #(.WIDTH(16), .DIGITS(5)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .bcd(bcd16), .seg(seg16)
  );

  bcd_seg_converter #(.WIDTH(1), .DIGITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .seg(seg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference segment table
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected 3-digit segment word, including optional leading-zero blanking
  function automatic logic [20:0] exp_seg3(input logic [11:0] v);
    logic [20:0] r;
    logic [3:0]  d;
    logic        lead;
    logic        lzb;
`ifdef BCD_SEG_LEADING_ZERO_BLANK_EN
    lzb = 1'b1;
`else
    lzb = 1'b0;
`endif
    r    = '0;
    lead = 1'b1;
    for (int k = 2; k >= 0; k--) begin
      d = v[k*4 +: 4];
      if (d != 4'd0) lead = 1'b0;
      r[k*7 +: 7] = (lzb && lead && k != 0) ? 7'b1111111 : seg_of(d);
    end
    return r;
  endfunction

  // Drive one conversion on the 8-bit instance and observe 14 cycles.
  // bin is scrambled after acceptance; an optional extra start pulse is sent.
  task automatic run_conv(input logic [7:0] b, input int restart_at, input logic [7:0] rb,
                          output int lat, output int busy_cyc, output int done_cnt,
                          output logic [11:0] pre_bcd, output logic [20:0] pre_seg);
    @(negedge clk);
    bin   = b;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = -1;
    busy_cyc = 0;
    done_cnt = 0;
    pre_bcd  = '0;
    pre_seg  = '0;
    for (int n = 1; n <= 14; n++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = n;
      end
      if (n == 8) begin
        pre_bcd = bcd;
        pre_seg = seg;
      end
      if (n == 2) bin = ~b;
      if (n == restart_at) begin
        start = 1'b1;
        bin   = rb;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b0;
    start16 = 1'b0;
    start1  = 1'b0;
    bin     = 8'hA5;
    bin16   = '0;
    bin1    = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
    end
    tests++;
    if (bcd !== 12'h000) begin
      fails++;
      $display("FAIL reset_bcd: got %h expected 000", bcd);
    end
    tests++;
    if (seg !== exp_seg3(12'h000)) begin
      fails++;
      $display("FAIL reset_seg: got %b expected %b", seg, exp_seg3(12'h000));
    end
    tests++;
    if (bcd16 !== 20'h0 || busy16 !== 1'b0 || bcd1 !== 4'h0) begin
      fails++;
      $display("FAIL reset_other: bcd16=%h busy16=%b bcd1=%h expected 0", bcd16, busy16, bcd1);
    end
    reset = 1'b0;
  endtask

  task automatic test_max();
    int lat, bc, dc;
    logic [11:0] pb;
    logic [20:0] ps;
    run_conv(8'd255, 0, 8'd0, lat, bc, dc, pb, ps);
    tests++;
    if (lat !== 9) begin
      fails++;
      $display("FAIL max_latency: got %0d expected 9", lat);
    end
    tests++;
    if (bc !== 9 || dc !== 1) begin
      fails++;
      $display("FAIL max_handshake: busy_cycles=%0d dones=%0d expected 9 1", bc, dc);
    end
    tests++;
    if (pb !== 12'h000) begin
      fails++;
      $display("FAIL max_hold: bcd before done %h expected 000", pb);
    end
    tests++;
    if (bcd !== 12'h255) begin
      fails++;
      $display("FAIL max_bcd: got %h expected 255", bcd);
    end
    tests++;
    if (seg !== {7'b0100100, 7'b0010010, 7'b0010010}) begin
      fails++;
      $display("FAIL max_seg: got %b expected 0100100_0010010_0010010", seg);
    end
  endtask

  task automatic test_zero();
    int lat, bc, dc;
    logic [11:0] pb;
    logic [20:0] ps;
    logic [20:0] exp_s;
`ifdef BCD_SEG_LEADING_ZERO_BLANK_EN
    exp_s = {7'b1111111, 7'b1111111, 7'b1000000};
`else
    exp_s = {7'b1000000, 7'b1000000, 7'b1000000};
`endif
    run_conv(8'd0, 0, 8'd0, lat, bc, dc, pb, ps);
    tests++;
    if (pb !== 12'h255) begin
      fails++;
      $display("FAIL zero_hold: bcd before done %h expected 255", pb);
    end
    tests++;
    if (bcd !== 12'h000) begin
      fails++;
      $display("FAIL zero_bcd: got %h expected 000", bcd);
    end
    tests++;
    if (seg !== exp_s) begin
      fails++;
      $display("FAIL zero_seg: got %b expected %b", seg, exp_s);
    end
  endtask

  task automatic test_digit_roll();
    int lat, bc, dc;
    logic [11:0] pb;
    logic [20:0] ps;
    run_conv(8'd9, 0, 8'd0, lat, bc, dc, pb, ps);
    tests++;
    if (bcd !== 12'h009 || seg !== exp_seg3(12'h009)) begin
      fails++;
      $display("FAIL roll_9: bcd=%h seg=%b expected 009 %b", bcd, seg, exp_seg3(12'h009));
    end
    run_conv(8'd10, 0, 8'd0, lat, bc, dc, pb, ps);
    tests++;
`ifdef BCD_SEG_LEADING_ZERO_BLANK_EN
    if (ps[13:7] !== 7'b1111111) begin
`else
    if (ps[13:7] !== 7'b1000000) begin
`endif
      fails++;
      $display("FAIL roll_pre_digit1: got %b before second done", ps[13:7]);
    end
    tests++;
    if (bcd !== 12'h010 || seg[13:7] !== 7'b1111001 || lat !== 9) begin
      fails++;
      $display("FAIL roll_10: bcd=%h digit1=%b lat=%0d expected 010 1111001 9", bcd, seg[13:7], lat);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc, dc;
    logic [11:0] pb;
    logic [20:0] ps;
    run_conv(8'd100, 3, 8'd37, lat, bc, dc, pb, ps);
    tests++;
    if (dc !== 1 || lat !== 9) begin
      fails++;
      $display("FAIL ignore_done: dones=%0d lat=%0d expected 1 9", dc, lat);
    end
    tests++;
    if (bcd !== 12'h100) begin
      fails++;
      $display("FAIL ignore_bcd: got %h expected 100", bcd);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, dc, late_done;
    logic [11:0] pb;
    logic [20:0] ps;
    @(negedge clk);
    bin   = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
      fails++;
      $display("FAIL abort_state: busy=%b done=%b bcd=%h expected 0 0 000", busy, done, bcd);
    end
    reset     = 1'b0;
    late_done = 0;
    for (int n = 0; n < 10; n++) begin
      if (done) late_done++;
      @(negedge clk);
    end
    tests++;
    if (late_done !== 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", late_done);
    end
    run_conv(8'd42, 0, 8'd0, lat, bc, dc, pb, ps);
    tests++;
    if (bcd !== 12'h042 || lat !== 9) begin
      fails++;
      $display("FAIL abort_recover: bcd=%h lat=%0d expected 042 9", bcd, lat);
    end
  endtask

  task automatic test_back_to_back();
    int cnt, first, last;
    @(negedge clk);
    bin   = 8'd123;
    start = 1'b1;
    cnt   = 0;
    first = -1;
    last  = -1;
    @(negedge clk);
    for (int n = 1; n <= 32; n++) begin
      if (done) begin
        cnt++;
        if (first < 0) first = n;
        last = n;
      end
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (cnt !== 3 || first !== 9 || last !== 29) begin
      fails++;
      $display("FAIL b2b_period: dones=%0d first=%0d last=%0d expected 3 9 29", cnt, first, last);
    end
    tests++;
    if (bcd !== 12'h123) begin
      fails++;
      $display("FAIL b2b_bcd: got %h expected 123", bcd);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_wide();
    int lat;
    @(negedge clk);
    bin16   = 16'hFFFF;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat     = -1;
    for (int n = 1; n <= 20; n++) begin
      if (done16 && lat < 0) lat = n;
      @(negedge clk);
    end
    tests++;
    if (lat !== 17 || bcd16 !== 20'h65535) begin
      fails++;
      $display("FAIL wide_65535: bcd16=%h lat=%0d expected 65535 17", bcd16, lat);
    end
    tests++;
    if (seg16 !== {seg_of(4'd6), seg_of(4'd5), seg_of(4'd5), seg_of(4'd3), seg_of(4'd5)}) begin
      fails++;
      $display("FAIL wide_seg: got %b", seg16);
    end
  endtask

  task automatic test_width1();
    int lat;
    for (int v = 1; v >= 0; v--) begin
      @(negedge clk);
      bin1   = 1'(v);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      lat    = -1;
      for (int n = 1; n <= 5; n++) begin
        if (done1 && lat < 0) lat = n;
        @(negedge clk);
      end
      tests++;
      if (lat !== 2 || bcd1 !== 4'(v) || seg1 !== seg_of(4'(v))) begin
        fails++;
        $display("FAIL width1_%0d: bcd1=%h seg1=%b lat=%0d expected %0d %b 2",
                 v, bcd1, seg1, lat, v, seg_of(4'(v)));
      end
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    bin     = '0;
    start16 = 1'b0;
    bin16   = '0;
    start1  = 1'b0;
    bin1    = '0;
    test_reset();
    test_max();
    test_zero();
    test_digit_roll();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_wide();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
